// File: rtl/clock_divider_multi.sv
// rtl/clock_divider_multi.sv - multi-channel runtime-programmable clock/tick divider
//
// Each channel divides clk_in by an active div with an active high time and
// emits a registered divided waveform (clk_out) plus a one-cycle tick at the
// start of every period. A single pending configuration slot is loaded over a
// valid/ready port and applied to its target at that channel's period boundary.
//
// Ports:
//   clk_in      - system clock, all logic on its rising edge
//   rst         - asynchronous active-low reset
//   enable      - per-channel run enable
//   sync        - restart the phase of every enabled channel
//   cfg_valid   - configuration request
//   cfg_ready   - pending slot is empty, a request can be accepted
//   cfg_channel - target channel of the request
//   cfg_div     - requested period in clk_in cycles
//   cfg_high    - requested high time in clk_in cycles
//   cfg_error   - one-cycle pulse after a rejected request
//   clk_out     - divided waveforms
//   tick        - one-cycle pulse at the start of each period
module clock_divider_multi #(
  parameter int CHANNELS    = 4,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 10,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic [CHANNELS-1:0]  enable,
  input  logic                 sync,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_channel,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [DIV_WIDTH-1:0] cfg_high,
  output logic                 cfg_error,
  output logic [CHANNELS-1:0]  clk_out,
  output logic [CHANNELS-1:0]  tick
);

  localparam logic [DIV_WIDTH-1:0] RESET_DIV  = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] RESET_HIGH = DIV_WIDTH'(DEFAULT_DIV / 2);

  logic                 pend_valid;
  logic [CH_W-1:0]      pend_ch;
  logic [DIV_WIDTH-1:0] pend_div;
  logic [DIV_WIDTH-1:0] pend_high;
  logic [CHANNELS-1:0]  apply;
  logic                 cfg_legal;
  logic                 cfg_accept;

  assign cfg_legal = (cfg_div >= DIV_WIDTH'(2)) &&
                     (cfg_high != '0) &&
                     (cfg_high < cfg_div) &&
                     (32'(cfg_channel) < 32'(CHANNELS));

  // cfg_ready is a pure function of registered state, never of cfg_valid.
  assign cfg_ready  = !pend_valid;
  assign cfg_accept = cfg_valid && !pend_valid;

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      pend_valid <= 1'b0;
      pend_ch    <= '0;
      pend_div   <= '0;
      pend_high  <= '0;
      cfg_error  <= 1'b0;
    end else begin
      cfg_error <= cfg_accept && !cfg_legal;
      // Accept and apply never coincide: apply needs a full slot, accept an empty one.
      if (cfg_accept && cfg_legal) begin
        pend_valid <= 1'b1;
        pend_ch    <= cfg_channel;
        pend_div   <= cfg_div;
        pend_high  <= cfg_high;
      end else if (|apply) begin
        pend_valid <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DIV_WIDTH-1:0] phase;
    logic [DIV_WIDTH-1:0] phase_n;
    logic [DIV_WIDTH-1:0] div_r;
    logic [DIV_WIDTH-1:0] high_r;
    logic [DIV_WIDTH-1:0] div_n;
    logic [DIV_WIDTH-1:0] high_n;
    logic                 running;
    logic                 wrap;
    logic                 clk_q;
    logic                 tick_q;

    assign wrap = running && (phase == div_r - DIV_WIDTH'(1));

    // Pending values land only where a new period begins (wrap, start, sync)
    // or where the channel is not producing a waveform at all.
    assign apply[i] = pend_valid && (pend_ch == CH_W'(i)) &&
                      (sync || !running || !enable[i] || wrap);
    assign div_n  = apply[i] ? pend_div  : div_r;
    assign high_n = apply[i] ? pend_high : high_r;

    // Phase restarts at 0 on start, sync, wrap and while disabled.
    always_comb begin
      phase_n = '0;
      if (enable[i] && running && !sync && !wrap)
        phase_n = phase + DIV_WIDTH'(1);
    end

    always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
        phase   <= '0;
        running <= 1'b0;
        div_r   <= RESET_DIV;
        high_r  <= RESET_HIGH;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        phase   <= phase_n;
        running <= enable[i];
        div_r   <= div_n;
        high_r  <= high_n;
        clk_q   <= enable[i] && (phase_n < high_n);
        tick_q  <= enable[i] && (phase_n == '0);
      end
    end

    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
  end

endmodule
